// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro used by the fetch stage: INSTR_FETCH_PERF_EN.
package cpu_pkg;

    localparam int          BUS_WIDTH = 16;
    localparam logic [15:0] NOP       = 16'h0000;
    localparam logic [3:0]  HALT_OP   = 4'hF;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Saturating increment for the 32-bit performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control from decode, instruction memory link and IF/ID outputs.
// With INSTR_FETCH_PERF_EN defined the bus also carries the fetch/stall counters.
interface instr_fetch_if #(
    parameter int BUS_WIDTH = cpu_pkg::BUS_WIDTH
) ();
    import cpu_pkg::*;

    logic                 stall;
    logic                 branch_taken;
    logic [BUS_WIDTH-1:0] branch_target;
    logic [BUS_WIDTH-1:0] instr_address;
    logic [BUS_WIDTH-1:0] instruction;
    logic [BUS_WIDTH-1:0] if_id_instr;
    logic [BUS_WIDTH-1:0] if_id_pc;
    logic                 if_id_valid;
    logic                 halted;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0]          fetch_count;
    logic [31:0]          stall_count;
`endif

    // Fetch unit side: drives the memory address and the IF/ID register.
    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  instruction,
        output instr_address,
        output if_id_instr,
        output if_id_pc,
        output if_id_valid,
        output halted
`ifdef INSTR_FETCH_PERF_EN
        ,
        output fetch_count,
        output stall_count
`endif
    );

    // Surrounding pipeline / memory side.
    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output instruction,
        input  instr_address,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_valid,
        input  halted
`ifdef INSTR_FETCH_PERF_EN
        ,
        input  fetch_count,
        input  stall_count
`endif
    );

endinterface

// File: rtl/program_counter.sv
// Program counter register with a load / hold / increment next-PC mux.
// Increment wraps modulo 2^BUS_WIDTH without any flag.
module program_counter
    import cpu_pkg::*;
#(
    parameter int                   BUS_WIDTH    = cpu_pkg::BUS_WIDTH,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_inc,
    input  logic                 i_hold,
    input  logic [BUS_WIDTH-1:0] i_target,
    output logic [BUS_WIDTH-1:0] o_pc
);

    logic [BUS_WIDTH-1:0] r_pc;
    logic [BUS_WIDTH-1:0] w_pc_next;

    // Next-PC select: a redirect beats hold, hold beats increment.
    always_comb begin
        // NOTE: default first so every path assigns w_pc_next and no latch is inferred.
        w_pc_next = r_pc;
        if (i_load) begin
            w_pc_next = i_target;
        end else if (i_hold) begin
            w_pc_next = r_pc;
        end else if (i_inc) begin
            w_pc_next = r_pc + BUS_WIDTH'(1);
        end
    end

    // PC register, forced to the reset vector the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every register samples pre-edge values, matching hardware.
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: BOOT/RUN/HALTED FSM, PC control and the IF/ID register.
// Memory is combinational, so the instruction at the PC is captured on the same edge.
// Optional macro INSTR_FETCH_PERF_EN adds saturating fetch/stall counters.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                   BUS_WIDTH    = cpu_pkg::BUS_WIDTH,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [3:0]           HALT_OP      = cpu_pkg::HALT_OP
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam logic [BUS_WIDTH-1:0] NOP_W = BUS_WIDTH'(NOP);

    fetch_state_t         r_state;
    fetch_state_t         w_state_next;

    logic                 w_pc_load;
    logic                 w_pc_inc;
    logic                 w_pc_hold;
    logic                 w_capture;
    logic                 w_flush;
    logic                 w_drop_valid;
    logic                 w_is_halt;
    logic [BUS_WIDTH-1:0] w_pc;

    logic [BUS_WIDTH-1:0] r_if_id_instr;
    logic [BUS_WIDTH-1:0] r_if_id_pc;
    logic                 r_if_id_valid;

    assign w_is_halt = (bus.instruction[BUS_WIDTH-1 -: 4] == HALT_OP);

    program_counter #(
        .BUS_WIDTH    (BUS_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_pc_load),
        .i_inc    (w_pc_inc),
        .i_hold   (w_pc_hold),
        .i_target (bus.branch_target),
        .o_pc     (w_pc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: BOOT lasts one edge, HALT capture parks, redirect resumes.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                if (!bus.branch_taken && !bus.stall && w_is_halt) begin
                    w_state_next = HALTED;
                end
            end
            HALTED: begin
                if (bus.branch_taken) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    // FSM outputs: PC control and IF/ID update strobes for this edge.
    always_comb begin
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_hold    = 1'b0;
        w_capture    = 1'b0;
        w_flush      = 1'b0;
        w_drop_valid = 1'b0;
        unique case (r_state)
            BOOT: begin
                w_pc_load = bus.branch_taken;
                w_pc_hold = !bus.branch_taken;
            end
            RUN: begin
                if (bus.branch_taken) begin
                    // Redirect wins over stall and over a HALT sitting at the PC.
                    w_pc_load = 1'b1;
                    w_flush   = 1'b1;
                end else if (bus.stall) begin
                    w_pc_hold = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    w_pc_hold = w_is_halt;
                    w_pc_inc  = !w_is_halt;
                end
            end
            HALTED: begin
                // Stall is ignored here; only a redirect moves the PC.
                w_pc_load    = bus.branch_taken;
                w_flush      = bus.branch_taken;
                w_pc_hold    = !bus.branch_taken;
                w_drop_valid = 1'b1;
            end
            default: begin
                w_pc_hold = 1'b1;
            end
        endcase
    end

    // IF/ID pipeline register: flush to NOP, capture, or just retire valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_id_instr <= NOP_W;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
        end else if (w_flush) begin
            r_if_id_instr <= NOP_W;
            r_if_id_valid <= 1'b0;
        end else if (w_capture) begin
            r_if_id_instr <= bus.instruction;
            r_if_id_pc    <= w_pc;
            r_if_id_valid <= 1'b1;
        end else if (w_drop_valid) begin
            r_if_id_valid <= 1'b0;
        end
    end

    assign bus.instr_address = w_pc;
    assign bus.if_id_instr   = r_if_id_instr;
    assign bus.if_id_pc      = r_if_id_pc;
    assign bus.if_id_valid   = r_if_id_valid;
    assign bus.halted        = (r_state == HALTED);

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;
    logic        w_stall_edge;

    assign w_stall_edge = (r_state == RUN) && bus.stall && !bus.branch_taken;

    // Saturating counters of captures and of stalled RUN edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_capture) begin
                r_fetch_count <= sat_inc32(r_fetch_count);
            end
            if (w_stall_edge) begin
                r_stall_count <= sat_inc32(r_stall_count);
            end
        end
    end

    assign bus.fetch_count = r_fetch_count;
    assign bus.stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written
// HALT / wrap / async-reset sequences, then random stimulus against a model.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int          BW = 16;
    localparam logic [15:0] RV = 16'h0000;

    logic clk;
    logic rst;

    instr_fetch_if #(.BUS_WIDTH(BW)) bus ();

    instr_fetch #(
        .BUS_WIDTH    (BW),
        .RESET_VECTOR (RV),
        .HALT_OP      (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational instruction memory.
    logic [15:0] mem [0:65535];
    assign bus.instruction = mem[bus.instr_address];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Default memory contents: opcode never equals HALT_OP.
    function automatic logic [15:0] base_word(input int a);
        logic [15:0] w;
        w = 16'(a * 13 + 165);
        return w & 16'h7FFF;
    endfunction

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic        e_halted;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic [15:0] t,
                                input logic [15:0] ea, input logic ev,
                                input logic [15:0] ep, input logic [15:0] ei);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t;
        v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_halted = 1'b0;
        return v;
    endfunction

    // Reference model: the observable fetch-stage state after each edge.
    logic [15:0] m_pc, m_instr, m_idpc;
    logic        m_valid, m_boot, m_halt;
    int          m_fetch, m_stall;

    task automatic model_reset();
        m_pc = RV; m_instr = 16'h0000; m_idpc = 16'h0000;
        m_valid = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
        m_fetch = 0; m_stall = 0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [15:0] t);
        logic [15:0] w;
        if (m_boot) begin
            m_boot = 1'b0;
            if (b) m_pc = t;
        end else if (m_halt) begin
            m_valid = 1'b0;
            if (b) begin
                m_pc = t; m_halt = 1'b0; m_instr = 16'h0000;
            end
        end else if (b) begin
            m_pc = t; m_instr = 16'h0000; m_valid = 1'b0;
        end else if (s) begin
            m_stall++;
        end else begin
            w = mem[m_pc];
            m_instr = w; m_idpc = m_pc; m_valid = 1'b1; m_fetch++;
            if (w[15:12] == HALT_OP) m_halt = 1'b1;
            else m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic check_vs_model(input string tag);
        check({tag, ".addr"},   32'(bus.instr_address), 32'(m_pc));
        check({tag, ".valid"},  32'(bus.if_id_valid),   32'(m_valid));
        check({tag, ".pc"},     32'(bus.if_id_pc),      32'(m_idpc));
        check({tag, ".instr"},  32'(bus.if_id_instr),   32'(m_instr));
        check({tag, ".halted"}, 32'(bus.halted),        32'(m_halt));
`ifdef INSTR_FETCH_PERF_EN
        check({tag, ".fetch_count"}, bus.fetch_count, 32'(m_fetch));
        check({tag, ".stall_count"}, bus.stall_count, 32'(m_stall));
`endif
    endtask

    // Apply inputs, let one rising edge pass, return 1 time unit after it.
    task automatic drive_edge(input logic s, input logic b, input logic [15:0] t);
        bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    vec_t vq[$];

    initial begin
        logic s, b;
        logic [15:0] t;
        rst = 1'b1;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = base_word(i);

        // ---- Reset state ----
        do_reset();
        check("reset.addr",   32'(bus.instr_address), 32'(RV));
        check("reset.valid",  32'(bus.if_id_valid),   32'd0);
        check("reset.pc",     32'(bus.if_id_pc),      32'd0);
        check("reset.instr",  32'(bus.if_id_instr),   32'd0);
        check("reset.halted", 32'(bus.halted),        32'd0);

        // ---- Directed table: sequential fetch, stall, redirect during stall ----
        vq.push_back(mk(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0));             // BOOT edge
        for (int k = 0; k < 24; k++)
            vq.push_back(mk(0, 0, 16'h0, 16'(k + 1), 1, 16'(k), base_word(k)));
        vq.push_back(mk(0, 1, 16'h4, 16'h4, 0, 16'd23, 16'h0));            // redirect to 4
        vq.push_back(mk(0, 0, 16'h0, 16'h5, 1, 16'h4, base_word(4)));       // pc now 5
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(1, 0, 16'h0, 16'h5, 1, 16'h4, base_word(4)));   // stall x3
        vq.push_back(mk(0, 0, 16'h0, 16'h6, 1, 16'h5, base_word(5)));
        vq.push_back(mk(0, 0, 16'h0, 16'h7, 1, 16'h6, base_word(6)));
        vq.push_back(mk(0, 0, 16'h0, 16'h8, 1, 16'h7, base_word(7)));
        vq.push_back(mk(1, 1, 16'h14, 16'h14, 0, 16'h7, 16'h0));            // redirect beats stall
        vq.push_back(mk(0, 0, 16'h0, 16'h15, 1, 16'h14, base_word(20)));
        for (int i = 0; i < vq.size(); i++) begin
            drive_edge(vq[i].stall, vq[i].br, vq[i].tgt);
            check($sformatf("vec%0d.addr", i),   32'(bus.instr_address), 32'(vq[i].e_addr));
            check($sformatf("vec%0d.valid", i),  32'(bus.if_id_valid),   32'(vq[i].e_valid));
            check($sformatf("vec%0d.pc", i),     32'(bus.if_id_pc),      32'(vq[i].e_pc));
            check($sformatf("vec%0d.instr", i),  32'(bus.if_id_instr),   32'(vq[i].e_instr));
            check($sformatf("vec%0d.halted", i), 32'(bus.halted),        32'(vq[i].e_halted));
        end
`ifdef INSTR_FETCH_PERF_EN
        check("perf.fetch_count", bus.fetch_count, 32'd29);
        check("perf.stall_count", bus.stall_count, 32'd3);
`endif

        // ---- HALT at address 3 ----
        mem[3] = 16'hF000;
        do_reset();
        drive_edge(0, 0, 16'h0);                                            // BOOT
        for (int k = 0; k < 3; k++) drive_edge(0, 0, 16'h0);                // capture 0..2
        drive_edge(0, 0, 16'h0);                                            // capture HALT
        check("halt.cap.instr", 32'(bus.if_id_instr),   32'h0000F000);
        check("halt.cap.valid", 32'(bus.if_id_valid),   32'd1);
        check("halt.cap.pc",    32'(bus.if_id_pc),      32'd3);
        check("halt.cap.addr",  32'(bus.instr_address), 32'd3);
        for (int k = 0; k < 10; k++) begin
            drive_edge(1'($urandom_range(0, 1)), 0, 16'h0);                 // stall ignored
            check($sformatf("halt.hold%0d.addr", k),   32'(bus.instr_address), 32'd3);
            check($sformatf("halt.hold%0d.halted", k), 32'(bus.halted),        32'd1);
            check($sformatf("halt.hold%0d.valid", k),  32'(bus.if_id_valid),   32'd0);
        end
        drive_edge(0, 1, 16'h0000);                                         // resume
        check("halt.exit.halted", 32'(bus.halted),        32'd0);
        check("halt.exit.addr",   32'(bus.instr_address), 32'd0);
        check("halt.exit.valid",  32'(bus.if_id_valid),   32'd0);
        drive_edge(0, 0, 16'h0);
        check("halt.resume.pc",    32'(bus.if_id_pc),      32'd0);
        check("halt.resume.valid", 32'(bus.if_id_valid),   32'd1);
        check("halt.resume.addr",  32'(bus.instr_address), 32'd1);
        drive_edge(0, 0, 16'h0);
        drive_edge(0, 0, 16'h0);                                            // pc now 3 (HALT)
        drive_edge(0, 1, 16'h0010);                                         // redirect vs HALT
        check("halt.flush.addr",   32'(bus.instr_address), 32'h10);
        check("halt.flush.valid",  32'(bus.if_id_valid),   32'd0);
        check("halt.flush.halted", 32'(bus.halted),        32'd0);
        drive_edge(0, 0, 16'h0);
        check("halt.flush.next.pc",     32'(bus.if_id_pc), 32'h10);
        check("halt.flush.next.halted", 32'(bus.halted),   32'd0);
        mem[3] = base_word(3);

        // ---- Branch in BOOT to 16'hFFFF, wrap, async reset mid-cycle ----
        do_reset();
        drive_edge(0, 1, 16'hFFFF);
        check("wrap.boot.addr",  32'(bus.instr_address), 32'h0000FFFF);
        check("wrap.boot.valid", 32'(bus.if_id_valid),   32'd0);
        drive_edge(0, 0, 16'h0);
        check("wrap.cap.pc",    32'(bus.if_id_pc),      32'h0000FFFF);
        check("wrap.cap.instr", 32'(bus.if_id_instr),   32'(base_word(65535)));
        check("wrap.cap.addr",  32'(bus.instr_address), 32'd0);
        drive_edge(0, 0, 16'h0);
        check("wrap.next.pc",   32'(bus.if_id_pc),      32'd0);
        check("wrap.next.addr", 32'(bus.instr_address), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst.addr",   32'(bus.instr_address), 32'(RV));
        check("async_rst.valid",  32'(bus.if_id_valid),   32'd0);
        check("async_rst.pc",     32'(bus.if_id_pc),      32'd0);
        check("async_rst.instr",  32'(bus.if_id_instr),   32'd0);
        check("async_rst.halted", 32'(bus.halted),        32'd0);

        // ---- Random stimulus against the model ----
        for (int i = 0; i < 40; i++) mem[$urandom_range(0, 255)] = {4'hF, 12'($urandom)};
        do_reset();
        check_vs_model("rnd.reset");
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 15) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                              : 16'($urandom_range(0, 255));
            model_step(s, b, t);
            drive_edge(s, b, t);
            check_vs_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives instr_address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decoder.
- Handles sequential fetch, stall, branch redirect/flush and HALT detection.

Parameters:
- BUS_WIDTH, 16: width of PC, address and instruction.
- RESET_VECTOR, 16'h0000: PC value loaded on reset.
- HALT_OP, 4'hF: opcode in instruction[BUS_WIDTH-1:BUS_WIDTH-4] that halts fetch.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and IF/ID register (decode backpressure)
- branch_taken  in  1  redirect request, one cycle pulse
- branch_target  in  BUS_WIDTH  redirect address, valid with branch_taken
- instr_address  out  BUS_WIDTH  current PC, to instruction memory
- instruction  in  BUS_WIDTH  instruction memory read data, combinational from instr_address
- if_id_instr  out  BUS_WIDTH  registered instruction to decode
- if_id_pc  out  BUS_WIDTH  address of if_id_instr
- if_id_valid  out  1  if_id_instr is a real instruction
- halted  out  1  fetch stopped on HALT

Behaviour:
- Reset (async, immediate):
  - pc = RESET_VECTOR
  - if_id_instr = 16'h0000 (NOP)
  - if_id_pc = 0
  - if_id_valid = 0
  - halted = 0
  - state = BOOT
- instr_address = pc, driven combinationally from the pc register. Memory is asynchronous, so the instruction is sampled in the same cycle: zero-wait fetch, one cycle latency to if_id_*.
- States:
  - BOOT: first clock edge after reset deasserts. No capture; if_id_valid stays 0; next state RUN; pc unchanged. The first valid instruction therefore appears one cycle later.
  - RUN, each edge, in priority order:
    1. branch_taken: pc <= branch_target; if_id_instr <= NOP; if_id_valid <= 0. Redirect overrides stall.
    2. stall: pc, if_id_* and state all hold.
    3. Otherwise: if_id_instr <= instruction; if_id_pc <= pc; if_id_valid <= 1; pc <= pc + 1.
  - HALT detection in RUN: if the captured instruction's opcode equals HALT_OP, the HALT is issued normally (valid=1), pc is not incremented, and next state is HALTED.
  - HALTED:
    - halted = 1; if_id_valid <= 0 from the next edge.
    - pc frozen; stall ignored.
    - branch_taken: pc <= branch_target, halted <= 0, state <= RUN.
    - rst also exits HALTED.
- PC increment wraps modulo 2^BUS_WIDTH: 16'hFFFF -> 16'h0000, with no flag.
- branch_taken in BOOT: pc <= branch_target; state <= RUN.
- Reset mid-stream: all registers return to reset values immediately; in-flight instruction discarded.
- If branch_taken and a HALT capture coincide, redirect wins and the HALT is flushed.

Optional Feature:
- Macro: INSTR_FETCH_PERF_EN
- Defined:
  - Adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on every edge with a capture (if_id_valid <= 1).
  - stall_count increments on every RUN edge with stall=1 and branch_taken=0.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cpu_pkg:
  - BUS_WIDTH default
  - NOP constant 16'h0000
  - HALT_OP
  - fetch_state_t enum {BOOT, RUN, HALTED}, 2 bits
- Sub-module program_counter: pc register with next-pc mux (hold / +1 / target). Control inputs: load, inc, hold.
- instr_fetch holds the FSM and the IF/ID register.

Test Plan:
1. Sequential fetch: memory preloaded at addresses 0..23, no stall/branch. After BOOT, if_id_pc steps 0,1,2,...,23 on consecutive cycles; if_id_instr equals mem[if_id_pc]; if_id_valid=1 throughout.
2. Stall: assert stall for 3 cycles while pc=5. instr_address holds 5; if_id_pc holds 4 and if_id_valid holds 1 for 3 cycles; fetch resumes with if_id_pc=5.
3. Redirect during stall: at pc=8, assert stall=1 and branch_taken=1 with branch_target=16'h0014. Next cycle pc=16'h0014, if_id_valid=0, if_id_instr=0; following cycle if_id_pc=16'h0014, valid=1.
4. HALT: mem[3]=16'hF000. Capture at pc=3 gives if_id_instr=16'hF000, valid=1. Next cycle halted=1, valid=0; instr_address stays 3 for 10 cycles. branch_taken to 16'h0000 clears halted.
5. Wrap and reset: force pc to 16'hFFFF via branch; next fetch pc=16'h0000. Assert rst asynchronously mid-cycle: instr_address=RESET_VECTOR and if_id_valid=0 before the next clock edge.
6. With INSTR_FETCH_PERF_EN: run scenario 2. fetch_count equals the number of valid captures; stall_count=3.
